// File: rtl/ysyx_22050078_mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ysyx_22050078_mem_pkg                                       |
// | Brief   : Shared types and constants for the memory responder.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package ysyx_22050078_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          c_data_width = 64;
    localparam int          c_strb_width = c_data_width / 8;
    localparam int          c_cnt_width  = 4;
    localparam logic [63:0] c_base_addr  = 64'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/ysyx_22050078_sram_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ysyx_22050078_sram_array                                    |
// | Brief   : Single-port 1RW array, byte-enabled write, registered read. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module ysyx_22050078_sram_array
    import ysyx_22050078_mem_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int STRB_WIDTH = c_strb_width,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  wen,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage is deliberately left unreset; only the read register holds data.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) begin
                for (int i = 0; i < STRB_WIDTH; i++) begin
                    if (wstrb[i]) begin
                        r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[idx];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ysyx_22050078_mem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ysyx_22050078_mem_responder                                 |
// | Brief   : Fixed-latency valid/ready memory responder over an SRAM.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module ysyx_22050078_mem_responder
    import ysyx_22050078_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = c_data_width,
    parameter int                    DEPTH_LOG2 = 12,
    parameter int                    LATENCY    = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(c_base_addr)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wen,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam logic [ADDR_WIDTH-1:0]  c_span     = ADDR_WIDTH'(1) << (DEPTH_LOG2 + 3);
    localparam logic [c_cnt_width-1:0] c_cnt_load = c_cnt_width'(LATENCY - 1);

    state_t                    r_state;
    logic [c_cnt_width-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic                      r_wen;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic                      r_rsp_valid;
    logic                      r_rsp_err;
    logic                      r_rd_ok;

    logic [ADDR_WIDTH-1:0]     w_off;
    logic                      w_in_range;
    logic                      w_fire;
    logic                      w_sram_en;
    logic [DATA_WIDTH-1:0]     w_sram_rdata;

    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_range = (r_addr >= BASE_ADDR) && (w_off < c_span);
    // The array is touched only on the edge that moves WAIT -> RESP.
    assign w_fire     = (r_state == WAIT) && (r_cnt == '0);
    assign w_sram_en  = w_fire && w_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_ok     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wen   <= req_wen;
                        r_wdata <= req_wdata;
                        r_wstrb <= req_wstrb;
                        r_cnt   <= c_cnt_load;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ~w_in_range;
                        r_rd_ok     <= w_in_range & ~r_wen;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_width'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rd_ok     <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ysyx_22050078_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (DATA_WIDTH/8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk   (clk),
        .en    (w_sram_en),
        .wen   (r_wen),
        .idx   (w_off[DEPTH_LOG2+2:3]),
        .wdata (r_wdata),
        .wstrb (r_wstrb),
        .rdata (w_sram_rdata)
    );

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    // Writes, errors and idle cycles present zero regardless of the array register.
    assign rsp_rdata = r_rd_ok ? w_sram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050078_mem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_ysyx_22050078_mem_responder                              |
// | Brief   : Directed self-checking bench, LATENCY=2 and LATENCY=4 DUTs. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_ysyx_22050078_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
    logic [63:0] req_addr  = '0;
    logic        req_wen   = 1'b0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        rsp_ready = 1'b0;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [63:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [63:0] b_rsp_rdata;
    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [63:0] m_rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22050078_mem_responder #(.LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    ysyx_22050078_mem_responder #(.LATENCY(4)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    assign m_req_ready = sel ? b_req_ready : a_req_ready;
    assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;

    // One complete request/response on the selected DUT; lat counts edges after acceptance.
    task automatic xact(input logic s, input logic [63:0] addr, input logic wen,
                        input logic [63:0] wdata, input logic [7:0] wstrb,
                        output int lat, output logic [63:0] rdata, output logic err);
        @(negedge clk);
        sel = s; req_addr = addr; req_wen = wen; req_wdata = wdata; req_wstrb = wstrb;
        if (s) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (m_rsp_valid) begin lat = k; break; end
        end
        rdata = m_rsp_rdata; err = m_rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        total++; if (a_rsp_rdata !== 64'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", a_rsp_rdata); end
        total++; if (a_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", a_rsp_err); end
    endtask

    task automatic test_write_read();
        int lat; logic [63:0] rd; logic er;
        xact(1'b0, 64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, lat, rd, er);
        total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        total++; if (rd !== 64'h0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", er); end
        total++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_return_idle got=%b%b exp=10", a_req_ready, a_rsp_valid); end
        xact(1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, lat, rd, er);
        total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        total++; if (rd !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL rd_rdata got=%h exp=1122334455667788", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL rd_err got=%b exp=0", er); end
    endtask

    task automatic test_partial_strobe();
        int lat; logic [63:0] rd; logic er;
        xact(1'b0, 64'h8000_0010, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, lat, rd, er);
        xact(1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h1122_3344_AAAA_AAAA) begin bad++; $display("FAIL partial_rdata got=%h exp=11223344aaaaaaaa", rd); end
        // Zero strobe write: normal response, no change.
        xact(1'b0, 64'h8000_0010, 1'b1, 64'h0, 8'h00, lat, rd, er);
        total++; if (er !== 1'b0 || lat !== 2) begin bad++; $display("FAIL zero_strb_rsp got=err%b lat%0d exp=err0 lat2", er, lat); end
        xact(1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h1122_3344_AAAA_AAAA) begin bad++; $display("FAIL zero_strb_rdata got=%h exp=11223344aaaaaaaa", rd); end
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] rd; logic er; logic [63:0] held;
        @(negedge clk);
        sel = 1'b0; req_addr = 64'h8000_0010; req_wen = 1'b0; a_req_valid = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        for (int k = 0; k < 20 && !a_rsp_valid; k++) @(negedge clk);
        held = a_rsp_rdata;
        total++; if (held !== 64'h1122_3344_AAAA_AAAA) begin bad++; $display("FAIL bp_first_rdata got=%h exp=11223344aaaaaaaa", held); end
        req_wen = 1'b1; req_wdata = 64'h0; req_wstrb = 8'hFF; a_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held cyc=%0d got=%b exp=1", k, a_rsp_valid); end
            total++; if (a_rsp_rdata !== 64'h1122_3344_AAAA_AAAA) begin bad++; $display("FAIL bp_rdata_held cyc=%0d got=%h exp=11223344aaaaaaaa", k, a_rsp_rdata); end
            total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", k, a_req_ready); end
        end
        a_req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b%b exp=01", a_rsp_valid, a_req_ready); end
        xact(1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h1122_3344_AAAA_AAAA) begin bad++; $display("FAIL bp_ignored_req got=%h exp=11223344aaaaaaaa", rd); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [63:0] rd; logic er;
        xact(1'b0, 64'h7FFF_FFF8, 1'b0, 64'h0, 8'h00, lat, rd, er);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_low_err got=%b exp=1", er); end
        total++; if (rd !== 64'h0) begin bad++; $display("FAIL oor_low_rdata got=%h exp=0", rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL oor_low_latency got=%0d exp=2", lat); end
        xact(1'b0, 64'h8000_0000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, rd, er);
        // 0x8000_8000 would alias word 0 if the range check were missing.
        xact(1'b0, 64'h8000_8000, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, lat, rd, er);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_high_err got=%b exp=1", er); end
        xact(1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL oor_no_write got=%h exp=0123456789abcdef", rd); end
        xact(1'b0, 64'h8000_7FF8, 1'b1, 64'hCAFE_F00D_0000_1234, 8'hFF, lat, rd, er);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL last_word_wr_err got=%b exp=0", er); end
        xact(1'b0, 64'h8000_7FFF, 1'b0, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'hCAFE_F00D_0000_1234 || er !== 1'b0) begin bad++; $display("FAIL last_word_rd got=%h err=%b exp=cafef00d00001234 err=0", rd, er); end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [63:0] rd; logic er; logic seen;
        xact(1'b1, 64'h8000_0020, 1'b1, 64'h5555_5555_5555_5555, 8'hFF, lat, rd, er);
        total++; if (lat !== 4) begin bad++; $display("FAIL l4_latency got=%0d exp=4", lat); end
        @(negedge clk);
        sel = 1'b1; req_addr = 64'h8000_0020; req_wen = 1'b1;
        req_wdata = 64'h6666_6666_6666_6666; req_wstrb = 8'hFF; b_req_valid = 1'b1;
        @(posedge clk);          // edge T
        #1 b_req_valid = 1'b0;
        @(posedge clk);          // T+1
        @(posedge clk);          // T+2
        #1 rst = 1'b1;
        #1;
        total++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=%b%b exp=10", b_req_ready, b_rsp_valid); end
        total++; if (b_rsp_rdata !== 64'h0 || b_rsp_err !== 1'b0) begin bad++; $display("FAIL midrst_data got=%h err=%b exp=0 err=0", b_rsp_rdata, b_rsp_err); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b_rsp_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_stale_rsp got=%b exp=0", seen); end
        xact(1'b1, 64'h8000_0020, 1'b0, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h5555_5555_5555_5555) begin bad++; $display("FAIL midrst_old_data got=%h exp=5555555555555555", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
